// File: rtl/mask_decode_32_pkg.sv
// ---------------------------------------------------------------------------
// mask_decode_32_pkg
// Shared constants and the thermometer-mask encoding function used by the
// mask decoder and its re-encoder.
//   MASK_W      : width of a thermometer mask (32)
//   IDX_W       : width of a mask index (5)
//   mask_encode : idx -> thermometer mask for a given FROM_MSB/DIAG_ONES
// ---------------------------------------------------------------------------
package mask_decode_32_pkg;

    localparam int MASK_W = 32;
    localparam int IDX_W  = 5;

    // Index n yields n ones (or n+1 ones when diag_ones is set), filled from
    // bit 0 upward or from bit 31 downward depending on from_msb.
    function automatic logic [MASK_W-1:0] mask_encode(
        input logic [IDX_W-1:0] idx,
        input logic             from_msb,
        input logic             diag_ones
    );
        logic [IDX_W:0]    onesCount;
        logic [MASK_W-1:0] m;
        onesCount = {1'b0, idx} + {{IDX_W{1'b0}}, diag_ones};
        m = '0;
        for (int i = 0; i < MASK_W; i++) begin
            if (i < int'(onesCount)) begin
                if (from_msb) begin
                    m[MASK_W-1-i] = 1'b1;
                end else begin
                    m[i] = 1'b1;
                end
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/mask_decode_32_mask32.sv
// ---------------------------------------------------------------------------
// mask_32
// Combinational 32-bit thermometer mask generator.
//   i_idx  : 5-bit index
//   o_mask : thermometer mask for i_idx under FROM_MSB/DIAG_ONES
// ---------------------------------------------------------------------------
module mask_32
    import mask_decode_32_pkg::*;
#(
    parameter logic FROM_MSB  = 1'b1,
    parameter logic DIAG_ONES = 1'b1
) (
    input  logic [IDX_W-1:0]  i_idx,
    output logic [MASK_W-1:0] o_mask
);

    assign o_mask = mask_encode(i_idx, FROM_MSB, DIAG_ONES);

endmodule

// File: rtl/mask_decode_32.sv
// ---------------------------------------------------------------------------
// mask_decode_32
// Recovers the 5-bit index from a 32-bit thermometer mask, flags masks that
// are not legal codes and keeps a saturating count of flagged results.
// Two-stage valid/ready pipeline: stage 1 priority-encodes, stage 2 checks
// legality by re-encoding the index and comparing it with the input mask.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : input handshake
//   in_mask              : thermometer mask to decode
//   out_valid/out_ready  : output handshake
//   out_idx, out_err     : decoded index and illegal-code flag
//   err_count            : saturating count of delivered out_err results
//   err_clr              : synchronous clear of err_count (wins over count)
// ---------------------------------------------------------------------------
module mask_decode_32
    import mask_decode_32_pkg::*;
#(
    parameter logic FROM_MSB  = 1'b1,
    parameter logic DIAG_ONES = 1'b1,
    parameter int   ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [MASK_W-1:0]    in_mask,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IDX_W-1:0]     out_idx,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count,
    input  logic                 err_clr
);

    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

    logic                 r_s1Valid;
    logic [IDX_W-1:0]     r_s1Idx;
    logic [MASK_W-1:0]    r_s1Mask;
    logic                 r_s2Valid;
    logic [IDX_W-1:0]     r_outIdx;
    logic                 r_outErr;
    logic [ERR_CNT_W-1:0] r_errCount;

    logic                 w_s2Load;
    logic                 w_inFire;
    logic                 w_outFire;
    logic [IDX_W:0]       w_pos;
    logic [IDX_W:0]       w_sum;
    logic [IDX_W-1:0]     w_encIdx;
    logic [MASK_W-1:0]    w_reMask;

    // Stage 2 takes stage 1's item whenever it is empty or draining.
    assign w_s2Load  = r_s1Valid && (!r_s2Valid || out_ready);
    assign in_ready  = !r_s1Valid || w_s2Load;
    assign w_inFire  = in_valid && in_ready;
    assign w_outFire = r_s2Valid && out_ready;

    assign out_valid = r_s2Valid;
    assign out_idx   = r_outIdx;
    assign out_err   = r_outErr;
    assign err_count = r_errCount;

    // Priority encoder: find the boundary bit of the ones run (highest set bit
    // for bottom-up fill, lowest set bit for top-down fill), convert it to an
    // index and saturate the 32-ones corner case to 31.
    always_comb begin
        w_pos    = '0;
        w_sum    = '0;
        w_encIdx = '0;
        if (FROM_MSB) begin
            for (int i = MASK_W - 1; i >= 0; i--) begin
                if (in_mask[i]) w_pos = (IDX_W+1)'(i);
            end
            w_sum = 6'd32 - w_pos - {5'd0, DIAG_ONES};
        end else begin
            for (int i = 0; i < MASK_W; i++) begin
                if (in_mask[i]) w_pos = (IDX_W+1)'(i);
            end
            w_sum = w_pos + 6'd1 - {5'd0, DIAG_ONES};
        end
        if (in_mask == '0) begin
            w_encIdx = '0;
        end else if (w_sum > 6'd31) begin
            w_encIdx = 5'd31;
        end else begin
            w_encIdx = w_sum[IDX_W-1:0];
        end
    end

    // Re-encoder for the legality check: any mask that does not round-trip
    // through index -> mask is illegal, which covers every illegal case.
    mask_32 #(
        .FROM_MSB  (FROM_MSB),
        .DIAG_ONES (DIAG_ONES)
    ) u_reEnc (
        .i_idx  (r_s1Idx),
        .o_mask (w_reMask)
    );

    // Stage 1 holds its item until stage 2 takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1Valid <= 1'b0;
            r_s1Idx   <= '0;
            r_s1Mask  <= '0;
        end else if (w_inFire) begin
            r_s1Valid <= 1'b1;
            r_s1Idx   <= w_encIdx;
            r_s1Mask  <= in_mask;
        end else if (w_s2Load) begin
            r_s1Valid <= 1'b0;
        end
    end

    // Stage 2 outputs stay frozen while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2Valid <= 1'b0;
            r_outIdx  <= '0;
            r_outErr  <= 1'b0;
        end else if (w_s2Load) begin
            r_s2Valid <= 1'b1;
            r_outIdx  <= r_s1Idx;
            r_outErr  <= (w_reMask != r_s1Mask);
        end else if (out_ready) begin
            r_s2Valid <= 1'b0;
        end
    end

    // Error counter counts delivered errors only; clear beats increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_errCount <= '0;
        end else if (err_clr) begin
            r_errCount <= '0;
        end else if (w_outFire && r_outErr && (r_errCount != ERR_MAX)) begin
            r_errCount <= r_errCount + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mask_decode_32.sv
// ---------------------------------------------------------------------------
// tb_mask_decode_32
// Directed bench for mask_decode_32 with three instances:
//   A: FROM_MSB=1, DIAG_ONES=1, 16-bit counter
//   B: FROM_MSB=0, DIAG_ONES=0, 16-bit counter
//   C: FROM_MSB=1, DIAG_ONES=1, 2-bit counter (saturation)
// ---------------------------------------------------------------------------
module tb_mask_decode_32;

    logic clk;
    logic rst_n;

    logic        inValidA, inReadyA, outValidA, outReadyA, outErrA, errClrA;
    logic [31:0] inMaskA;
    logic [4:0]  outIdxA;
    logic [15:0] errCountA;

    logic        inValidB, inReadyB, outValidB, outReadyB, outErrB, errClrB;
    logic [31:0] inMaskB;
    logic [4:0]  outIdxB;
    logic [15:0] errCountB;

    logic        inValidC, inReadyC, outValidC, outReadyC, outErrC, errClrC;
    logic [31:0] inMaskC;
    logic [4:0]  outIdxC;
    logic [1:0]  errCountC;

    int checks   = 0;
    int failures = 0;

    mask_decode_32 #(.FROM_MSB(1'b1), .DIAG_ONES(1'b1), .ERR_CNT_W(16)) dutA (
        .clk(clk), .rst_n(rst_n),
        .in_valid(inValidA), .in_ready(inReadyA), .in_mask(inMaskA),
        .out_valid(outValidA), .out_ready(outReadyA), .out_idx(outIdxA),
        .out_err(outErrA), .err_count(errCountA), .err_clr(errClrA)
    );

    mask_decode_32 #(.FROM_MSB(1'b0), .DIAG_ONES(1'b0), .ERR_CNT_W(16)) dutB (
        .clk(clk), .rst_n(rst_n),
        .in_valid(inValidB), .in_ready(inReadyB), .in_mask(inMaskB),
        .out_valid(outValidB), .out_ready(outReadyB), .out_idx(outIdxB),
        .out_err(outErrB), .err_count(errCountB), .err_clr(errClrB)
    );

    mask_decode_32 #(.FROM_MSB(1'b1), .DIAG_ONES(1'b1), .ERR_CNT_W(2)) dutC (
        .clk(clk), .rst_n(rst_n),
        .in_valid(inValidC), .in_ready(inReadyC), .in_mask(inMaskC),
        .out_valid(outValidC), .out_ready(outReadyC), .out_idx(outIdxC),
        .out_err(outErrC), .err_count(errCountC), .err_clr(errClrC)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transfer into A, checking the 2-clock latency and the result.
    task automatic applyStimulusA(input string tag, input logic [31:0] mask,
                                  input logic [4:0] expIdx, input logic expErr);
        inValidA = 1'b1;
        inMaskA  = mask;
        checkOutput({tag, "_inready"}, 32'(inReadyA), 32'd1);
        step();
        inValidA = 1'b0;
        checkOutput({tag, "_early"}, 32'(outValidA), 32'd0);
        step();
        checkOutput({tag, "_valid"}, 32'(outValidA), 32'd1);
        checkOutput({tag, "_idx"}, 32'(outIdxA), 32'(expIdx));
        checkOutput({tag, "_err"}, 32'(outErrA), 32'(expErr));
    endtask

    task automatic applyStimulusB(input string tag, input logic [31:0] mask,
                                  input logic [4:0] expIdx, input logic expErr);
        inValidB = 1'b1;
        inMaskB  = mask;
        step();
        inValidB = 1'b0;
        checkOutput({tag, "_early"}, 32'(outValidB), 32'd0);
        step();
        checkOutput({tag, "_valid"}, 32'(outValidB), 32'd1);
        checkOutput({tag, "_idx"}, 32'(outIdxB), 32'(expIdx));
        checkOutput({tag, "_err"}, 32'(outErrB), 32'(expErr));
    endtask

    task automatic applyStimulusC(input string tag, input logic [31:0] mask);
        inValidC = 1'b1;
        inMaskC  = mask;
        step();
        inValidC = 1'b0;
        step();
        checkOutput({tag, "_valid"}, 32'(outValidC), 32'd1);
        checkOutput({tag, "_err"}, 32'(outErrC), 32'd1);
    endtask

    initial begin
        logic [31:0] pat;
        logic        prevStall;
        logic [4:0]  prevIdx;
        logic        expReady;
        int          sent;
        int          recv;

        rst_n = 1'b0;
        inValidA = 0; inMaskA = '0; outReadyA = 1; errClrA = 0;
        inValidB = 0; inMaskB = '0; outReadyB = 1; errClrB = 0;
        inValidC = 0; inMaskC = '0; outReadyC = 1; errClrC = 0;

        // Reset state
        #12;
        checkOutput("rst_valid", 32'(outValidA), 32'd0);
        checkOutput("rst_idx", 32'(outIdxA), 32'd0);
        checkOutput("rst_err", 32'(outErrA), 32'd0);
        checkOutput("rst_count", 32'(errCountA), 32'd0);
        rst_n = 1'b1;
        step();
        checkOutput("rst_inreadyA", 32'(inReadyA), 32'd1);
        checkOutput("rst_inreadyB", 32'(inReadyB), 32'd1);
        checkOutput("rst_inreadyC", 32'(inReadyC), 32'd1);

        $display("[TB] legal masks, top-down fill with diagonal");
        applyStimulusA("t1_ffff8000", 32'hFFFF8000, 5'd16, 1'b0);
        applyStimulusA("t1_80000000", 32'h80000000, 5'd0, 1'b0);

        $display("[TB] illegal masks, top-down fill with diagonal");
        applyStimulusA("t3_f0f00000", 32'hF0F00000, 5'd11, 1'b1);
        applyStimulusA("t3_zero", 32'h00000000, 5'd0, 1'b1);
        step();
        checkOutput("t3_count", 32'(errCountA), 32'd2);

        $display("[TB] bottom-up fill without diagonal");
        applyStimulusB("t2_zero", 32'h00000000, 5'd0, 1'b0);
        applyStimulusB("t2_7fffffff", 32'h7FFFFFFF, 5'd31, 1'b0);
        applyStimulusB("t2_ffffffff", 32'hFFFFFFFF, 5'd31, 1'b1);
        step();
        checkOutput("t2_count", 32'(errCountB), 32'd1);

        $display("[TB] narrow counter saturation");
        for (int k = 0; k < 5; k++) begin
            applyStimulusC("t5_sat", 32'h00000000);
        end
        step();
        checkOutput("t5_sat_count", 32'(errCountC), 32'd3);

        $display("[TB] backpressure stream");
        pat       = 32'hB5A3C96D;
        prevStall = 1'b0;
        prevIdx   = '0;
        sent      = 0;
        recv      = 0;
        for (int cyc = 0; cyc < 300 && recv < 32; cyc++) begin
            inValidA  = (sent < 32);
            inMaskA   = ~(32'hFFFFFFFF >> (sent + 1));
            outReadyA = pat[cyc % 32];
            #3;
            expReady = ((sent - recv) < 2) || outReadyA;
            checkOutput("bp_inready", 32'(inReadyA), 32'(expReady));
            if (prevStall) begin
                checkOutput("bp_hold_valid", 32'(outValidA), 32'd1);
                checkOutput("bp_hold_idx", 32'(outIdxA), 32'(prevIdx));
            end
            if (outValidA) begin
                checkOutput("bp_idx", 32'(outIdxA), 32'(recv));
                checkOutput("bp_err", 32'(outErrA), 32'd0);
            end
            prevStall = outValidA && !outReadyA;
            prevIdx   = outIdxA;
            if (outValidA && outReadyA) recv++;
            if (inValidA && inReadyA) sent++;
            step();
        end
        inValidA  = 1'b0;
        outReadyA = 1'b1;
        checkOutput("bp_received", 32'(recv), 32'd32);
        checkOutput("bp_sent", 32'(sent), 32'd32);

        $display("[TB] clear against erroring transfer");
        applyStimulusA("t5_clr", 32'h00000000, 5'd0, 1'b1);
        errClrA = 1'b1;
        step();
        errClrA = 1'b0;
        checkOutput("t5_clr_count", 32'(errCountA), 32'd0);

        $display("[TB] async reset with both stages full");
        applyStimulusA("t6_pre", 32'h00FF0000, 5'd15, 1'b1);
        step();
        checkOutput("t6_pre_count", 32'(errCountA), 32'd1);
        outReadyA = 1'b0;
        inValidA  = 1'b1;
        inMaskA   = 32'hC0000000;
        step();
        inMaskA   = 32'hE0000000;
        step();
        inValidA  = 1'b0;
        checkOutput("t6_full_inready", 32'(inReadyA), 32'd0);
        checkOutput("t6_full_valid", 32'(outValidA), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_valid", 32'(outValidA), 32'd0);
        checkOutput("t6_rst_count", 32'(errCountA), 32'd0);
        checkOutput("t6_rst_idx", 32'(outIdxA), 32'd0);
        #2;
        rst_n     = 1'b1;
        outReadyA = 1'b1;
        step();
        checkOutput("t6_no_ghost", 32'(outValidA), 32'd0);
        applyStimulusA("t6_post", 32'hF8000000, 5'd4, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
